board_read_arbiter: RTL

BOARD_READ_ARBITER -- requirements
Module: board_read_arbiter

---
 rtl/board_read_arbiter_pkg.sv | 35 +++
 rtl/board_read_arbiter_rr_pick.sv | 61 ++++++
 rtl/board_read_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/board_read_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// board_read_arbiter_pkg
// Shared constants and helpers for the board read arbiter.
//   - requester indices (win checker, display scanner, debug controller)
//   - board geometry (6 rows x 7 columns, 3-bit coordinates)
//   - empty-piece code returned for reads that never touch the board
// -----------------------------------------------------------------------------
package board_read_arbiter_pkg;

    // Requester indices
    localparam int REQ_WIN  = 0;
    localparam int REQ_DISP = 1;
    localparam int REQ_DBG  = 2;

    // Board geometry
    localparam int BOARD_ROWS = 6;
    localparam int BOARD_COLS = 7;
    localparam int COORD_W    = 3;

    // Piece code for an empty cell; also returned for off-board reads
    localparam logic [1:0] PIECE_EMPTY = 2'b00;

    typedef logic [COORD_W-1:0] coord_t;

    // True when (row, col) addresses a real board cell
    function automatic logic addr_in_board(input coord_t row, input coord_t col);
        return (int'(row) < BOARD_ROWS) && (int'(col) < BOARD_COLS);
    endfunction

    // Width of a requester index; at least one bit even for a single requester
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/board_read_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational winner selection.
//   req      : eligible requests (already masked by the caller)
//   ptr      : index of the last granted requester
//   prio     : priority mask; any request also set here wins outright
//   win      : one-hot winner (zero when no request)
//   win_idx  : binary index of the winner (0 when no request)
//   win_any  : a winner exists
// Without a priority hit, the search starts at ptr+1 and wraps.
// -----------------------------------------------------------------------------
module rr_pick
    import board_read_arbiter_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int PW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    input  logic [NREQ-1:0] prio,
    output logic [NREQ-1:0] win,
    output logic [PW-1:0]   win_idx,
    output logic            win_any
);

    logic [NREQ-1:0] pri_req;
    logic [PW-1:0]   cand;

    always_comb begin
        win     = '0;
        win_idx = '0;
        win_any = 1'b0;
        cand    = '0;
        pri_req = req & prio;

        if (|pri_req) begin
            // Walk downward so the lowest-index priority request is the last write
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (pri_req[i]) begin
                    win_idx = PW'(i);
                    win_any = 1'b1;
                end
            end
        end else begin
            // Walk the circular order backwards: the final hit is the one
            // closest after ptr, i.e. the round-robin winner
            for (int k = NREQ; k >= 1; k--) begin
                cand = PW'((int'(ptr) + k) % NREQ);
                if (req[cand]) begin
                    win_idx = cand;
                    win_any = 1'b1;
                end
            end
        end

        if (win_any) begin
            win[win_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/board_read_arbiter.sv
// -----------------------------------------------------------------------------
// board_read_arbiter
// Shares one combinational board read port among NREQ requesters.
//
// Timing for a win decided at edge N:
//   cycle N+1 : gnt[i], brd_rd_en, brd_row/brd_col (registered winner address)
//   edge  N+1 : brd_data captured
//   cycle N+2 : rd_valid[i] with rd_data
// One grant per cycle; reads pipeline behind grants in grant order.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   e_debug           : debug mode; debug requester gets priority, else ignored
//   req               : one request per requester, held until its gnt
//   req_row, req_col  : 3-bit address per requester, packed NREQ x 3
//   gnt               : one-hot grant pulse
//   rd_valid, rd_data : one-hot read-data-valid pulse and shared piece code
//   brd_rd_en         : board read strobe (0 for off-board addresses)
//   brd_row, brd_col  : board address, held when idle
//   brd_data          : board piece, combinational from brd_row/brd_col
// -----------------------------------------------------------------------------
module board_read_arbiter
    import board_read_arbiter_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  e_debug,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*3-1:0]     req_row,
    input  logic [NREQ*3-1:0]     req_col,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       rd_valid,
    output logic [1:0]            rd_data,
    output logic                  brd_rd_en,
    output logic [2:0]            brd_row,
    output logic [2:0]            brd_col,
    input  logic [1:0]            brd_data
);

    localparam int PW = idx_w(NREQ);

    // Per-requester address views
    logic [NREQ-1:0][COORD_W-1:0] row_v;
    logic [NREQ-1:0][COORD_W-1:0] col_v;

    assign row_v = req_row;
    assign col_v = req_col;

    // Registered state
    logic [NREQ-1:0] gnt_q,      gnt_d;
    logic [NREQ-1:0] rd_valid_q, rd_valid_d;
    logic [1:0]      rd_data_q,  rd_data_d;
    logic            brd_rd_en_q, brd_rd_en_d;
    coord_t          brd_row_q,  brd_row_d;
    coord_t          brd_col_q,  brd_col_d;
    logic [PW-1:0]   ptr_q,      ptr_d;

    // Arbitration inputs/outputs
    logic [NREQ-1:0] dbg_mask;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] prio_mask;
    logic [NREQ-1:0] win;
    logic [PW-1:0]   win_idx;
    logic            win_any;

    always_comb begin
        dbg_mask  = NREQ'(1) << REQ_DBG;
        // A requester in its grant cycle is still holding req; skip it so a
        // stale request is not granted twice.
        elig      = req & ~gnt_q & (e_debug ? {NREQ{1'b1}} : ~dbg_mask);
        prio_mask = e_debug ? dbg_mask : '0;
    end

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .req     (elig),
        .ptr     (ptr_q),
        .prio    (prio_mask),
        .win     (win),
        .win_idx (win_idx),
        .win_any (win_any)
    );

    always_comb begin
        gnt_d       = win;
        ptr_d       = ptr_q;
        brd_row_d   = brd_row_q;
        brd_col_d   = brd_col_q;
        brd_rd_en_d = 1'b0;

        if (win_any) begin
            ptr_d       = win_idx;
            brd_row_d   = row_v[win_idx];
            brd_col_d   = col_v[win_idx];
            // Off-board addresses are granted but never strobe the board
            brd_rd_en_d = addr_in_board(row_v[win_idx], col_v[win_idx]);
        end

        // Read return stage follows the grant stage by one cycle. brd_rd_en_q
        // is only set alongside a grant, so idle cycles return the empty code.
        rd_valid_d = gnt_q;
        rd_data_d  = brd_rd_en_q ? brd_data : PIECE_EMPTY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q       <= '0;
            rd_valid_q  <= '0;
            rd_data_q   <= PIECE_EMPTY;
            brd_rd_en_q <= 1'b0;
            brd_row_q   <= '0;
            brd_col_q   <= '0;
            ptr_q       <= PW'(NREQ - 1);
        end else begin
            gnt_q       <= gnt_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            brd_rd_en_q <= brd_rd_en_d;
            brd_row_q   <= brd_row_d;
            brd_col_q   <= brd_col_d;
            ptr_q       <= ptr_d;
        end
    end

    assign gnt       = gnt_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign brd_rd_en = brd_rd_en_q;
    assign brd_row   = brd_row_q;
    assign brd_col   = brd_col_q;

endmodule
